// File: rtl/de10_lite_sopc_touch_panel_spi_if.sv
// Avalon-MM slave bus bundle for the touch-panel SPI master.
// The master modport is the CPU/interconnect side; the slave modport is the peripheral side.
interface de10_lite_sopc_touch_panel_spi_if;
    logic [1:0]  address;
    logic        chipselect;
    logic        write_n;
    logic [31:0] writedata;
    logic [31:0] readdata;
    logic        irq;

    modport master (
        output address, chipselect, write_n, writedata,
        input  readdata, irq
    );

    modport slave (
        input  address, chipselect, write_n, writedata,
        output readdata, irq
    );
endinterface

// File: rtl/de10_lite_sopc_touch_panel_spi.sv
// SPI master for an XPT2046-class touch controller: one 24-DCLK frame per CMD write, 12-bit result, done irq.
// Start latency 1 clk, frame is 50*(DIV+1) clks with cs_n low; CMD writes while busy are dropped.
module de10_lite_sopc_touch_panel_spi #(
    parameter int unsigned DEFAULT_DIV = 24
) (
    input  logic                                  clk,
    input  logic                                  reset_n,
    de10_lite_sopc_touch_panel_spi_if.slave       avs,
    output logic                                  spi_cs_n,
    output logic                                  spi_sclk,
    output logic                                  spi_mosi,
    input  logic                                  spi_miso
);

    typedef enum logic [1:0] {IDLE, SETUP, SHIFT, HOLD} state_t;

    state_t      state;
    logic [7:0]  cmd;
    logic [7:0]  clkdiv;
    logic [7:0]  lim;
    logic [7:0]  cnt;
    logic [11:0] data;
    logic        done;
    logic        irq_en;
    logic [5:0]  tog;
    logic [23:0] rx;

    logic        wr;
    logic        wr_cmd;
    logic        wr_status;
    logic        wr_div;
    logic        tick;
    logic        busy;
    logic [5:0]  fall_k;
    logic [2:0]  bit_idx;

    assign wr        = avs.chipselect & ~avs.write_n;
    assign wr_cmd    = wr && (avs.address == 2'd0);
    assign wr_status = wr && (avs.address == 2'd2);
    assign wr_div    = wr && (avs.address == 2'd3);
    assign tick      = (cnt == lim);
    assign busy      = (state != IDLE);
    assign avs.irq   = done & irq_en;

    // tog counts sclk toggles already made; an odd tog means the next toggle is falling edge (tog+1)/2
    assign fall_k  = (tog + 6'd1) >> 1;
    assign bit_idx = 3'd7 - fall_k[2:0];

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state        <= IDLE;
            cmd          <= 8'd0;
            clkdiv       <= 8'(DEFAULT_DIV);
            lim          <= 8'(DEFAULT_DIV);
            cnt          <= 8'd0;
            data         <= 12'd0;
            done         <= 1'b0;
            irq_en       <= 1'b0;
            tog          <= 6'd0;
            rx           <= 24'd0;
            spi_cs_n     <= 1'b1;
            spi_sclk     <= 1'b0;
            spi_mosi     <= 1'b0;
            avs.readdata <= 32'd0;
        end else begin
            if (wr_div) begin
                clkdiv <= avs.writedata[7:0];
            end
            // HOLD exit below overrides this clear when both land in the same cycle
            if (wr_status) begin
                done   <= 1'b0;
                irq_en <= avs.writedata[8];
            end

            case (state)
                IDLE: begin
                    if (wr_cmd) begin
                        cmd      <= avs.writedata[7:0];
                        lim      <= clkdiv;
                        cnt      <= 8'd0;
                        spi_cs_n <= 1'b0;
                        spi_mosi <= avs.writedata[7];
                        state    <= SETUP;
                    end
                end
                SETUP: begin
                    if (tick) begin
                        cnt      <= 8'd0;
                        spi_sclk <= 1'b1;
                        rx       <= {rx[22:0], spi_miso};
                        tog      <= 6'd1;
                        state    <= SHIFT;
                    end else begin
                        cnt <= cnt + 8'd1;
                    end
                end
                SHIFT: begin
                    if (tick) begin
                        cnt <= 8'd0;
                        // after the 48th toggle sclk idles low for one more half-period before HOLD
                        if (tog == 6'd48) begin
                            state <= HOLD;
                        end else begin
                            tog      <= tog + 6'd1;
                            spi_sclk <= ~spi_sclk;
                            if (!spi_sclk) begin
                                rx <= {rx[22:0], spi_miso};
                            end else if (tog < 6'd14) begin
                                spi_mosi <= cmd[bit_idx];
                            end else begin
                                spi_mosi <= 1'b0;
                            end
                        end
                    end else begin
                        cnt <= cnt + 8'd1;
                    end
                end
                HOLD: begin
                    if (tick) begin
                        cnt      <= 8'd0;
                        data     <= rx[14:3];
                        done     <= 1'b1;
                        spi_cs_n <= 1'b1;
                        state    <= IDLE;
                    end else begin
                        cnt <= cnt + 8'd1;
                    end
                end
                default: state <= IDLE;
            endcase

            case (avs.address)
                2'd0:    avs.readdata <= {24'd0, cmd};
                2'd1:    avs.readdata <= {20'd0, data};
                2'd2:    avs.readdata <= {23'd0, irq_en, 6'd0, done, busy};
                default: avs.readdata <= {24'd0, clkdiv};
            endcase
        end
    end

endmodule

// File: tb/tb_de10_lite_sopc_touch_panel_spi.sv
// Self-checking bench: register table, directed frame corner cases, randomized frames against a frame-level model.
module tb_de10_lite_sopc_touch_panel_spi;

    logic clk = 1'b0;
    logic reset_n;
    logic spi_cs_n, spi_sclk, spi_mosi, spi_miso;

    de10_lite_sopc_touch_panel_spi_if bus ();

    de10_lite_sopc_touch_panel_spi #(.DEFAULT_DIV(24)) dut (
        .clk      (clk),
        .reset_n  (reset_n),
        .avs      (bus),
        .spi_cs_n (spi_cs_n),
        .spi_sclk (spi_sclk),
        .spi_mosi (spi_mosi),
        .spi_miso (spi_miso)
    );

    always #5 clk = ~clk;

    int tests = 0;
    int fails = 0;

    // Touch controller model: presents bit (23 - rises seen) of frame_bits, so sample k gets frame_bits[24-k].
    logic [23:0] frame_bits = 24'd0;
    int          rise_cnt = 0;
    always @(negedge spi_cs_n) rise_cnt = 0;
    always @(posedge spi_sclk) rise_cnt = rise_cnt + 1;
    always_comb begin
        spi_miso = 1'b0;
        if (rise_cnt >= 0 && rise_cnt < 24) spi_miso = frame_bits[5'(23 - rise_cnt)];
    end

    typedef struct {
        bit          do_wr;
        logic [1:0]  addr;
        logic [31:0] wdata;
        logic [31:0] exp;
    } reg_vec_t;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic bus_write(input logic [1:0] a, input logic [31:0] d);
        @(negedge clk);
        bus.address = a; bus.chipselect = 1'b1; bus.write_n = 1'b0; bus.writedata = d;
        @(negedge clk);
        bus.chipselect = 1'b0; bus.write_n = 1'b1;
    endtask

    task automatic bus_read(input logic [1:0] a, output logic [31:0] d);
        @(negedge clk);
        bus.address = a;
        @(negedge clk);
        d = bus.readdata;
    endtask

    // Issues a CMD write and watches the frame until cs_n returns high; optional single write at cycle mid_idx.
    task automatic run_frame(input logic [7:0] c, input logic [11:0] v, input int h,
                             input int mid_idx, input logic [1:0] mid_addr, input logic [31:0] mid_data,
                             output int low, output int rises, output int first_rise, output int spacing_err,
                             output logic [7:0] mb, output logic [31:0] st_mid, output logic irq_end);
        int   last_rise;
        logic prev, s_cs, s_sclk, s_mosi, finished;
        frame_bits = {9'($urandom), v, 3'($urandom)};
        low = 0; rises = 0; first_rise = -1; spacing_err = 0; mb = 8'd0; st_mid = 32'd0;
        irq_end = 1'b0; prev = 1'b0; last_rise = 0; finished = 1'b0;
        @(negedge clk);
        bus.address = 2'd0; bus.chipselect = 1'b1; bus.write_n = 1'b0; bus.writedata = {24'd0, c};
        for (int idx = 0; idx < 4000; idx++) begin
            @(negedge clk);
            s_cs = spi_cs_n; s_sclk = spi_sclk; s_mosi = spi_mosi;
            bus.chipselect = (idx == mid_idx);
            bus.write_n    = (idx != mid_idx);
            bus.address    = (idx == mid_idx) ? mid_addr : 2'd2;
            bus.writedata  = mid_data;
            if (s_cs) begin
                irq_end = bus.irq;
                finished = 1'b1;
                break;
            end
            low++;
            if (idx == 10) st_mid = bus.readdata;
            if (s_sclk && !prev) begin
                rises++;
                if (rises == 1) first_rise = idx;
                else if (idx - last_rise != 2 * h) spacing_err++;
                last_rise = idx;
                if (rises <= 8) mb[8 - rises] = s_mosi;
            end
            prev = s_sclk;
        end
        bus.chipselect = 1'b0; bus.write_n = 1'b1;
        check("frame_terminates", 32'(finished), 32'd1);
    endtask

    task automatic idle_low_count(input int n, output int cnt);
        cnt = 0;
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            if (!spi_cs_n) cnt++;
        end
    endtask

    initial begin
        reg_vec_t    vecs[8];
        logic [31:0] rd;
        logic [31:0] st;
        logic [7:0]  mb, c;
        logic [11:0] v;
        logic        irq_end;
        int          low, rises, fr, sp, idle_cnt, d;
        bit          hit;

        bus.address = 2'd0; bus.chipselect = 1'b0; bus.write_n = 1'b1; bus.writedata = 32'd0;
        reset_n = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk) reset_n = 1'b1;

        check("reset_cs_n", 32'(spi_cs_n), 32'd1);
        check("reset_sclk", 32'(spi_sclk), 32'd0);
        check("reset_mosi", 32'(spi_mosi), 32'd0);
        check("reset_irq",  32'(bus.irq),  32'd0);

        vecs[0] = '{1'b0, 2'd0, 32'h0,         32'h0};
        vecs[1] = '{1'b0, 2'd1, 32'h0,         32'h0};
        vecs[2] = '{1'b0, 2'd2, 32'h0,         32'h0};
        vecs[3] = '{1'b0, 2'd3, 32'h0,         32'd24};
        vecs[4] = '{1'b1, 2'd3, 32'hFFFF_FFAB, 32'hAB};
        vecs[5] = '{1'b1, 2'd2, 32'h0000_0100, 32'h100};
        vecs[6] = '{1'b1, 2'd2, 32'hFFFF_FEFF, 32'h0};
        vecs[7] = '{1'b1, 2'd3, 32'h0,         32'h0};
        foreach (vecs[i]) begin
            if (vecs[i].do_wr) bus_write(vecs[i].addr, vecs[i].wdata);
            bus_read(vecs[i].addr, rd);
            check($sformatf("reg_vec%0d", i), rd, vecs[i].exp);
        end

        // basic frame at DIV=0
        run_frame(8'h93, 12'hA5C, 1, -1, 2'd0, 32'd0, low, rises, fr, sp, mb, st, irq_end);
        check("basic_cs_low",   32'(low), 32'd50);
        check("basic_rises",    32'(rises), 32'd24);
        check("basic_first",    32'(fr), 32'd1);
        check("basic_spacing",  32'(sp), 32'd0);
        check("basic_mosi",     32'(mb), 32'h93);
        check("basic_st_mid",   st, 32'h001);
        check("basic_irq_off",  32'(irq_end), 32'd0);
        bus_read(2'd1, rd); check("basic_data", rd, 32'hA5C);
        bus_read(2'd2, rd); check("basic_status", rd, 32'h002);

        // irq enabled: rises with done, cleared by a STATUS write
        bus_write(2'd2, 32'h100);
        run_frame(8'hC4, 12'h3E7, 1, -1, 2'd0, 32'd0, low, rises, fr, sp, mb, st, irq_end);
        check("irq_st_mid", st, 32'h101);
        check("irq_at_done", 32'(irq_end), 32'd1);
        bus_write(2'd2, 32'h100);
        check("irq_cleared", 32'(bus.irq), 32'd0);

        // busy lockout
        bus_write(2'd2, 32'h0);
        run_frame(8'hD0, 12'h111, 1, 20, 2'd0, 32'h90, low, rises, fr, sp, mb, st, irq_end);
        check("lock_mosi", 32'(mb), 32'hD0);
        check("lock_cs_low", 32'(low), 32'd50);
        bus_read(2'd0, rd); check("lock_cmd", rd, 32'hD0);
        idle_low_count(60, idle_cnt); check("lock_one_frame", 32'(idle_cnt), 32'd0);

        // STATUS write coinciding with the HOLD exit: done set wins
        bus_write(2'd2, 32'h0);
        run_frame(8'h91, 12'h222, 1, 49, 2'd2, 32'h0, low, rises, fr, sp, mb, st, irq_end);
        bus_read(2'd2, rd); check("hold_exit_done_wins", rd, 32'h002);

        // CMD write coinciding with the HOLD exit is dropped
        run_frame(8'h92, 12'h333, 1, 49, 2'd0, 32'h55, low, rises, fr, sp, mb, st, irq_end);
        bus_read(2'd0, rd); check("hold_exit_cmd_ignored", rd, 32'h92);
        idle_low_count(20, idle_cnt); check("hold_exit_no_frame", 32'(idle_cnt), 32'd0);

        // divider latched at frame start; mid-frame CLKDIV write affects only the next frame
        bus_write(2'd3, 32'd3);
        run_frame(8'hB1, 12'h9C3, 4, 30, 2'd3, 32'd0, low, rises, fr, sp, mb, st, irq_end);
        check("div_cs_low",  32'(low), 32'd200);
        check("div_first",   32'(fr), 32'd4);
        check("div_spacing", 32'(sp), 32'd0);
        check("div_rises",   32'(rises), 32'd24);
        bus_read(2'd1, rd); check("div_data", rd, 32'h9C3);
        bus_read(2'd3, rd); check("div_new_clkdiv", rd, 32'h0);

        // randomized frames against the frame-level model
        for (int i = 0; i < 6; i++) begin
            d = $urandom_range(0, 3);
            c = 8'($urandom);
            v = 12'($urandom);
            bus_write(2'd3, 32'(d));
            run_frame(c, v, d + 1, -1, 2'd0, 32'd0, low, rises, fr, sp, mb, st, irq_end);
            check($sformatf("rnd%0d_cs_low", i), 32'(low), 32'(50 * (d + 1)));
            check($sformatf("rnd%0d_mosi", i), 32'(mb), 32'(c));
            check($sformatf("rnd%0d_rises", i), 32'(rises), 32'd24);
            bus_read(2'd1, rd); check($sformatf("rnd%0d_data", i), rd, 32'(v));
        end

        // reset asserted at rising edge 12
        bus_write(2'd3, 32'd0);
        frame_bits = 24'hFFFFFF;
        @(negedge clk);
        bus.address = 2'd0; bus.chipselect = 1'b1; bus.write_n = 1'b0; bus.writedata = 32'h97;
        hit = 1'b0;
        for (int i = 0; i < 200; i++) begin
            @(negedge clk);
            bus.chipselect = 1'b0; bus.write_n = 1'b1;
            if (rise_cnt == 12) begin hit = 1'b1; break; end
        end
        check("rst_mid_reached_edge12", 32'(hit), 32'd1);
        reset_n = 1'b0;
        #1;
        check("rst_mid_cs_n", 32'(spi_cs_n), 32'd1);
        check("rst_mid_sclk", 32'(spi_sclk), 32'd0);
        @(negedge clk) reset_n = 1'b1;
        bus_read(2'd1, rd); check("rst_mid_data", rd, 32'h0);
        bus_read(2'd2, rd); check("rst_mid_status", rd, 32'h0);
        bus_read(2'd3, rd); check("rst_mid_clkdiv", rd, 32'd24);
        run_frame(8'h95, 12'h5A6, 25, -1, 2'd0, 32'd0, low, rises, fr, sp, mb, st, irq_end);
        check("post_rst_cs_low", 32'(low), 32'd1250);
        check("post_rst_mosi", 32'(mb), 32'h95);
        bus_read(2'd1, rd); check("post_rst_data", rd, 32'h5A6);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/de10_lite_sopc_touch_panel_spi.md
# de10_lite_sopc_touch_panel_spi

Avalon-MM slave SPI master driving the resistive touch controller (XPT2046/ADS7843 class) on the DE10-Lite touch panel header. Software writes an 8-bit control byte. The block runs one 24-DCLK conversion frame and captures the 12-bit result. It then raises a maskable completion interrupt. It is the command/data side of the touch interface: the separate pen-IRQ PIO tells software a touch is present, and this block reads the coordinates.

## Interface
Parameters:
- DEFAULT_DIV, 24, reset value of CLKDIV. DCLK = clk / (2*(DIV+1)), so the default gives 1 MHz at 50 MHz.

Ports:
- clk  in  1  system clock
- reset_n  in  1  asynchronous, active-low reset
- address  in  2  register word address
- chipselect  in  1  slave select
- write_n  in  1  active-low write strobe
- writedata  in  32  write data
- readdata  out  32  registered read data; reset 0
- irq  out  1  done & irq_en; reset 0
- spi_cs_n  out  1  controller chip select; reset 1
- spi_sclk  out  1  DCLK, idle low; reset 0
- spi_mosi  out  1  controller DIN; reset 0
- spi_miso  in  1  controller DOUT; treated as synchronous to the sampling point, no extra synchronizer

## Operation
Register map (wr = chipselect & ~write_n):
- addr 0 CMD: [7:0] RW. A write while idle stores the byte and starts a frame. A write while busy is ignored and the register is unchanged. Reset 0.
- addr 1 DATA: [11:0] RO, last captured result. Reset 0.
- addr 2 STATUS: bit0 busy (RO), bit1 done, bit8 irq_en (RW). Any write to this address clears done and loads irq_en from writedata[8]. Reset: all 0.
- addr 3 CLKDIV: [7:0] RW. Reset DEFAULT_DIV. The value is latched into the half-period counter limit at frame start, so a write mid-frame applies only to the next frame.
- readdata: updated every clk from the address mux, zero-extended; reads have no side effects.

FSM states:
- IDLE: cs_n=1, sclk=0, mosi=0. A CMD write moves to SETUP.
- SETUP: cs_n=0, mosi=CMD[7], for H=DIV+1 clks. Then go to SHIFT.
- SHIFT: sclk toggles every H clks, 24 rising edges total, ending with sclk low after falling edge 24. Then go to HOLD.
  - Rising edge k (k=1..24): rx <= {rx[22:0], spi_miso}.
  - Falling edge k (k=1..7): mosi <= CMD[7-k].
  - Falling edge k >= 8: mosi <= 0.
- HOLD: cs_n=0, sclk=0 for H clks. Then DATA <= rx[14:3] (the MISO samples at rising edges 10..21, MSB first), done <= 1, cs_n <= 1, go to IDLE.
- busy = (state != IDLE).

Boundary rules:
- The HOLD-exit done set and a STATUS write in the same cycle: set wins.
- A CMD write in the same cycle as the HOLD exit is ignored, because the block is still busy.
- Starting a new frame does not clear done; software clears it.
- DIV=0 gives the fastest mode, sclk = clk/2, and must work.
- Reset asserted mid-frame: outputs go to reset values asynchronously and the FSM returns to IDLE. No done is set and DATA keeps its reset value 0.

## Timing
- CMD write sampled at edge T: busy=1 and cs_n=0 from T+1. This one-cycle start latency is fixed.
- First sclk rise at T+1+H. Rising edge k at T+1+(2k-1)H. Last fall at T+1+48H.
- done=1 and cs_n=1 from T+1+50H. irq is combinational from the registered done/irq_en, so it is visible in the same cycle.
- Frame cs_n-low duration is exactly 50H clks. The minimum idle gap between frames is 1 clk (cs_n high at least 1 clk).
- readdata reflects a register one clk after the address is presented. A read at T+1+50H returns the new DATA on the following cycle.

## Test plan
- Reset: after reset, readdata=0 at every address except CLKDIV=24, and irq=0, cs_n=1, sclk=0, mosi=0.
- Basic frame, DIV=0: write CMD=0x93 with a MISO model returning 12'hA5C. Required response:
  - mosi bits 1,0,0,1,0,0,1,1 across rising edges 1-8;
  - 24 sclk pulses;
  - cs_n low for exactly 50 clks;
  - DATA=0xA5C; STATUS=0x001 during the frame and 0x002 after it.
- IRQ: write STATUS=0x100, then run a frame. irq rises with done. Writing STATUS=0x100 clears irq the next cycle.
- Busy lockout: write CMD=0xD0, then write CMD=0x90 mid-frame. CMD reads back 0xD0, only one frame occurs, and mosi carries 0xD0.
- Divider: write CLKDIV=3, then run a frame. The sclk half-period is 4 clks and the frame is 200 clks. A CLKDIV=0 write mid-frame does not alter the current frame.
- Reset mid-frame: assert reset_n=0 at rising edge 12. cs_n=1 and sclk=0 immediately, DATA=0, done=0. After release, a new frame completes normally.
